var_delay_line: RTL and testbench
=================================

// Module: var_delay_line
// PURPOSE
//  Run-time-selectable delay line for complex (re/im) FFT datapaths. Replaces the fixed 9-tap register chain
//  with a parametrised circular buffer: width, maximum depth and tap are generic, the delay is gated by a
//  sample enable, and an out_valid flag reports when the selected tap holds real history.
//  Sits between butterfly stages and in the twiddle-alignment path of the 1-D FFT pipeline.
// PARAMETERS
//  WIDTH      16  bits per real/imag component (signed two's complement)
//  MAX_DELAY  16  largest supported delay in accepted samples (>=2, need not be a power of 2)
//  DNUM_W     5   width of dnum; must satisfy 2**DNUM_W > MAX_DELAY
// PORTS
//  clk        in   1        single clock, all state updates on rising edge
//  rst        in   1        synchronous, active-high reset
//  en         in   1        sample enable: in_re/in_im accepted on this edge when 1
//  dnum       in   DNUM_W   selected delay in accepted samples (1..MAX_DELAY)
//  in_re      in   WIDTH    signed real input
//  in_im      in   WIDTH    signed imag input
//  out_re     out  WIDTH    signed real output, sample accepted dnum enables ago
//  out_im     out  WIDTH    signed imag output
//  out_valid  out  1        selected tap holds a genuinely accepted sample
//  dnum_err   out  1        dnum==0 or dnum>MAX_DELAY
//  flush      in   1        only with VAR_DELAY_FLUSH_EN (see CONFIGURATION)
// BEHAVIOUR
//  State: mem[0..MAX_DELAY-1] (2*WIDTH each), wr_ptr (0..MAX_DELAY-1), fill (0..MAX_DELAY, saturating).
//  Reset (rst=1 at edge): wr_ptr=0, fill=0, every mem entry=0; rst overrides en and flush. Outputs
//   follow combinationally: out_re=out_im=0, out_valid=0, dnum_err from current dnum.
//  en=1 edge: mem[wr_ptr]<={in_re,in_im}; wr_ptr<=(wr_ptr==MAX_DELAY-1)?0:wr_ptr+1; fill<=min(fill+1,MAX_DELAY).
//  en=0 edge: no state change; outputs hold (delay counts accepted samples, not clocks).
//  Read (combinational from state and dnum): rd = (wr_ptr>=dnum) ? wr_ptr-dnum : wr_ptr+MAX_DELAY-dnum.
//   With en held 1, a sample presented at edge t is on out_* from just after edge t+dnum-1 until edge t+dnum
//   (dnum=1 -> one clock of latency, identical to the old single-register tap).
//  dnum_err = (dnum==0) || (dnum>MAX_DELAY).  out_valid = !dnum_err && (fill>=dnum).
//  out_re/out_im = out_valid ? mem[rd] : 0  -- never expose stale or reset contents.
//  dnum change mid-stream: takes effect combinationally; no refill penalty if fill>=new dnum, otherwise
//   out_valid drops until enough samples are accepted. Buffer contents untouched.
//  Wrap-around: wr_ptr wraps MAX_DELAY-1->0; dnum=MAX_DELAY reads the slot about to be overwritten
//   (read is pre-edge, so the oldest sample is still correct).
//  Arithmetic: no data arithmetic; pointer math in $clog2(MAX_DELAY)+1 bits to avoid underflow.
// CONFIGURATION
//  VAR_DELAY_FLUSH_EN defined: flush port present. flush=1 edge (rst=0): fill<=0, wr_ptr<=0, mem kept;
//   flush overrides en (sample on that edge dropped). out_valid=0 next cycle for any dnum.
//  Undefined: no flush port; fill only cleared by rst.
// STRUCTURE
//  Shared header fft_delay_defs.h: default WIDTH/MAX_DELAY/DNUM_W, `DNumBus/`CalcTempBus defines.
//  One sub-module: delay_ram (MAX_DELAY x 2*WIDTH register array, 1 write port, 1 async read port,
//   synchronous clear on rst). Pointer/fill control and output masking stay in var_delay_line.
// TESTING
//  1 rst, then en=1, dnum=1, in_re=1,2,3.. -> out_re=k one clock after k; out_valid from cycle after 1st en.
//  2 dnum=9, in 1..20 continuous -> out_valid rises after 9th en edge; out_re trails in_re by 9; matches old chain.
//  3 en toggled 1,0,1,0.. with dnum=3 -> out only advances on en edges; 3 accepted samples delay, not 3 clocks.
//  4 MAX_DELAY=16, dnum=16, 40 samples -> wrap twice, out_re=k-16 exactly, no glitch at wr_ptr 15->0.
//  5 dnum 4->12 after 6 samples -> out_valid=0, out=0 until fill=12; dnum 12->2 later -> valid immediately.
//  6 dnum=0 and dnum=17 -> dnum_err=1, out_valid=0, out=0; rst mid-stream -> all outputs 0 next cycle;
//    with VAR_DELAY_FLUSH_EN, flush+en same edge -> sample dropped, fill=0.

Source files
------------

// File: rtl/var_delay_line_pkg.sv
// Shared defaults and helpers for the run-time-selectable complex delay line.
// Optional build macro used by this block: VAR_DELAY_FLUSH_EN (adds the flush port).
package var_delay_line_pkg;

    localparam int unsigned DEF_WIDTH     = 16;
    localparam int unsigned DEF_MAX_DELAY = 16;
    localparam int unsigned DEF_DNUM_W    = 5;

    // One bit wider than an index into the buffer, so wr_ptr + MAX_DELAY cannot overflow.
    function automatic int unsigned ptr_width(input int unsigned max_delay);
        return $clog2(max_delay) + 1;
    endfunction

endpackage

// File: rtl/var_delay_line_delay_ram.sv
// MAX_DELAY x 2*WIDTH register array: one synchronous write port, one asynchronous read port,
// whole-array synchronous clear on rst.
module var_delay_line_delay_ram #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // NOTE: the array is cleared on rst on purpose (a register file, not a RAM macro), so a
    // slot that has never been written reads as zero rather than X.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/var_delay_line.sv
// Complex (re/im) delay line with run-time tap select, sample-enable gating and a valid flag.
// Build macro VAR_DELAY_FLUSH_EN adds a flush port that empties the line without touching data.
module var_delay_line
    import var_delay_line_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned MAX_DELAY = DEF_MAX_DELAY,
    parameter int unsigned DNUM_W    = DEF_DNUM_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic        [DNUM_W-1:0] dnum,
    input  logic signed [WIDTH-1:0]  in_re,
    input  logic signed [WIDTH-1:0]  in_im,
`ifdef VAR_DELAY_FLUSH_EN
    input  logic                     flush,
`endif
    output logic signed [WIDTH-1:0]  out_re,
    output logic signed [WIDTH-1:0]  out_im,
    output logic                     out_valid,
    output logic                     dnum_err
);

    localparam int unsigned AW = $clog2(MAX_DELAY);
    localparam int unsigned PW = ptr_width(MAX_DELAY);
    localparam logic [PW-1:0] MAX_P    = PW'(MAX_DELAY);
    localparam logic [AW-1:0] LAST_PTR = AW'(MAX_DELAY - 1);

    logic [AW-1:0]        wr_ptr;
    logic [PW-1:0]        fill;
    logic                 clr;
    logic                 wr_en;
    logic [PW-1:0]        dnum_c;
    logic [PW-1:0]        wr_ext;
    logic [PW-1:0]        rd_calc;
    logic [AW-1:0]        rd_addr;
    logic [2*WIDTH-1:0]   rd_word;

`ifdef VAR_DELAY_FLUSH_EN
    assign clr = flush;
`else
    assign clr = 1'b0;
`endif

    // Delay is counted in accepted samples, so nothing moves on an en=0 edge.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            fill   <= '0;
        end else if (en) begin
            wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + AW'(1);
            fill   <= (fill == MAX_P) ? fill : fill + PW'(1);
        end
    end

    assign wr_en = en && !clr;

    var_delay_line_delay_ram #(
        .WORD_W (2 * WIDTH),
        .DEPTH  (MAX_DELAY),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata ({in_re, in_im}),
        .raddr (rd_addr),
        .rdata (rd_word)
    );

    assign dnum_err = (dnum == '0) || (dnum > DNUM_W'(MAX_DELAY));

    // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
    always_comb begin
        dnum_c  = dnum_err ? '0 : PW'(dnum);
        wr_ext  = {1'b0, wr_ptr};
        rd_calc = '0;
        if (wr_ext >= dnum_c) begin
            rd_calc = wr_ext - dnum_c;
        end else begin
            rd_calc = wr_ext + MAX_P - dnum_c;
        end
    end

    // rd_calc MSB is zero for any legal dnum; it is folded in as a guard against a bad index.
    assign out_valid = !dnum_err && (fill >= dnum_c) && !rd_calc[PW-1];
    assign rd_addr   = rd_calc[AW-1:0];

    assign out_re = out_valid ? rd_word[2*WIDTH-1 -: WIDTH] : '0;
    assign out_im = out_valid ? rd_word[WIDTH-1:0]         : '0;

endmodule

// File: tb/tb_var_delay_line.sv
// Directed, table-driven bench for var_delay_line (WIDTH=16, MAX_DELAY=16, DNUM_W=5).
// Define VAR_DELAY_FLUSH_EN for both bench and RTL to also exercise the flush port.
module tb_var_delay_line;

    localparam int W = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic        [4:0]   dnum;
    logic signed [W-1:0] in_re;
    logic signed [W-1:0] in_im;
    logic signed [W-1:0] out_re;
    logic signed [W-1:0] out_im;
    logic                out_valid;
    logic                dnum_err;
`ifdef VAR_DELAY_FLUSH_EN
    logic                flush = 1'b0;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    var_delay_line #(.WIDTH(16), .MAX_DELAY(16), .DNUM_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .dnum      (dnum),
        .in_re     (in_re),
        .in_im     (in_im),
`ifdef VAR_DELAY_FLUSH_EN
        .flush     (flush),
`endif
        .out_re    (out_re),
        .out_im    (out_im),
        .out_valid (out_valid),
        .dnum_err  (dnum_err)
    );

    typedef struct {
        logic                rst;
        logic                en;
        logic [4:0]          dnum;
        logic signed [W-1:0] in_re;
        logic                exp_valid;
        logic                exp_err;
        logic signed [W-1:0] exp_re;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input int d, input int din,
                       input logic v, input logic er, input int dout);
        vec_t t;
        t.rst = r; t.en = e; t.dnum = 5'(d); t.in_re = W'(din);
        t.exp_valid = v; t.exp_err = er; t.exp_re = W'(dout);
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, $signed(act), act, $signed(exp), exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic er, input logic signed [W-1:0] re);
        logic signed [W-1:0] im_exp;
        im_exp = -re;
        check({tag, "_valid"}, 32'(out_valid), 32'(v));
        check({tag, "_err"},   32'(dnum_err),  32'(er));
        check({tag, "_re"},    32'(out_re),    32'(re));
        check({tag, "_im"},    32'(out_im),    32'(im_exp));
    endtask

    task automatic step(input logic r, input logic e, input int d, input int din);
        rst = r; en = e; dnum = 5'(d); in_re = W'(din); in_im = -W'(din);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; dnum = 5'd1; in_re = '0; in_im = '0;

        // reset state
        add(1, 0, 1, 0, 0, 0, 0);
        // dnum=1: one clock of latency
        for (int k = 1; k <= 5; k++) add(0, 1, 1, k, 1, 0, k);
        // dnum=9 continuous stream
        add(1, 0, 9, 0, 0, 0, 0);
        for (int k = 1; k <= 20; k++) add(0, 1, 9, k, k >= 9, 0, (k >= 9) ? k - 8 : 0);
        // en toggling: delay counts accepted samples only
        add(1, 0, 3, 0, 0, 0, 0);
        for (int j = 1; j <= 12; j++) begin
            int n;
            n = (j + 1) / 2;
            add(0, j % 2 == 1, 3, 100 + j, n >= 3, 0, (n >= 3) ? 100 + 2 * n - 5 : 0);
        end
        // dnum=MAX_DELAY, 40 samples, wraps twice
        add(1, 0, 16, 0, 0, 0, 0);
        for (int k = 1; k <= 40; k++) add(0, 1, 16, k, k >= 16, 0, (k >= 16) ? k - 15 : 0);
        // dnum 4 -> 12 after 6 samples, then 12 -> 2
        add(1, 0, 4, 0, 0, 0, 0);
        for (int k = 1; k <= 6; k++) add(0, 1, 4, k, k >= 4, 0, (k >= 4) ? k - 3 : 0);
        add(0, 0, 12, 0, 0, 0, 0);
        for (int k = 7; k <= 12; k++) add(0, 1, 12, k, k >= 12, 0, (k >= 12) ? k - 11 : 0);
        add(0, 0, 2, 0, 1, 0, 11);
        // illegal dnum, short fill, then reset mid-stream
        add(0, 0, 0,  0, 0, 1, 0);
        add(0, 0, 17, 0, 0, 1, 0);
        add(0, 0, 31, 0, 0, 1, 0);
        add(0, 0, 16, 0, 0, 0, 0);
        add(0, 0, 12, 0, 1, 0, 1);
        add(1, 1, 2, 55, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 1, 77, 1, 0, 77);
        add(0, 1, 2, 78, 1, 0, 77);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].en, int'(vecs[i].dnum), int'(vecs[i].in_re));
            check_out($sformatf("v%0d", i), vecs[i].exp_valid, vecs[i].exp_err, vecs[i].exp_re);
        end

        // Full buffer 1..16, then sweep every tap with no clock edges in between.
        step(1, 0, 16, 0);
        for (int k = 1; k <= 16; k++) step(0, 1, 16, k);
        en = 1'b0;
        for (int d = 1; d <= 16; d++) begin
            dnum = 5'(d);
            #1;
            check_out($sformatf("sweep_d%0d", d), 1'b1, 1'b0, W'(17 - d));
        end
        // Idle edges must not advance the line.
        for (int k = 0; k < 3; k++) step(0, 0, 16, 999);
        check_out("hold_idle", 1'b1, 1'b0, W'(1));
        step(0, 1, 16, 17);
        check_out("after_idle", 1'b1, 1'b0, W'(2));

`ifdef VAR_DELAY_FLUSH_EN
        // flush together with en: sample dropped, line empty, data kept for later refill.
        flush = 1'b1;
        step(0, 1, 1, 500);
        flush = 1'b0;
        check_out("flush_d1", 1'b0, 1'b0, W'(0));
        dnum = 5'd16;
        #1;
        check_out("flush_d16", 1'b0, 1'b0, W'(0));
        step(0, 1, 1, 501);
        check_out("flush_refill", 1'b1, 1'b0, W'(501));
        step(0, 1, 2, 502);
        check_out("flush_refill2", 1'b1, 1'b0, W'(501));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
